// File: rtl/dsm_pkg.sv
// Shared definitions for the delta-sigma receive path: CIC defaults, width helper,
// signed saturation and the PCM sample type used by downstream checkers.
package dsm_pkg;

    localparam int CIC_ORDER     = 3;
    localparam int CIC_DECIM     = 32;
    localparam int CIC_OUT_WIDTH = 16;

    typedef logic signed [CIC_OUT_WIDTH-1:0] pcm_t;

    // Register growth of a sinc^order filter is order*log2(decim); +2 covers the +/-1 input.
    function automatic int cic_width(input int order, input int decim);
        return order * $clog2(decim) + 2;
    endfunction

    // Clamp a signed value to the range of a width-bit two's complement word.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int                width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/dsm_cic_if.sv
// Bitstream-in / PCM-out bundle between a delta-sigma source and the CIC decimator.
interface dsm_cic_if #(
    parameter int OUT_WIDTH = dsm_pkg::CIC_OUT_WIDTH
);
    logic                        clk_en;
    logic                        dsm_in;
    logic signed [OUT_WIDTH-1:0] pcm_out;
    logic                        pcm_valid;

    modport master (
        output clk_en,
        output dsm_in,
        input  pcm_out,
        input  pcm_valid
    );

    modport slave (
        input  clk_en,
        input  dsm_in,
        output pcm_out,
        output pcm_valid
    );
endinterface

// File: rtl/cic_integrator.sv
// One CIC integrator stage: a W-bit accumulator that wraps modulo 2^W and only
// advances on qualified input samples.
module cic_integrator #(
    parameter int W = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic signed [W-1:0] x_i,
    output logic signed [W-1:0] acc_o
);

    logic signed [W-1:0] acc_q;
    logic signed [W-1:0] acc_d;

    // NOTE: the default assignment ahead of the if keeps this block free of inferred latches.
    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = acc_q + x_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/dsm_cic_decimator.sv
// sinc^ORDER decimator turning a 1-bit delta-sigma stream into signed PCM, one word
// per DECIM qualified input bits.
module dsm_cic_decimator
    import dsm_pkg::*;
#(
    parameter int ORDER     = CIC_ORDER,
    parameter int DECIM     = CIC_DECIM,
    parameter int OUT_WIDTH = CIC_OUT_WIDTH
) (
    input  logic      clk,
    input  logic      rst,
    dsm_cic_if.slave  bus
);

    localparam int W     = cic_width(ORDER, DECIM);
    localparam int SHIFT = W - 1 - OUT_WIDTH;
    localparam int CW    = $clog2(DECIM);

    logic signed [W-1:0] integ [ORDER+1];
    logic signed [W-1:0] comb_c [ORDER+1];
    logic signed [W-1:0] dly_q [ORDER];
    logic signed [W-1:0] comb_shifted;

    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        tick_q, tick_d;
    logic signed [OUT_WIDTH-1:0] pcm_q, pcm_d;
    logic                        valid_q;

    // Input bit maps to +1 / -1 in the full internal width.
    assign integ[0] = bus.dsm_in ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};

    for (genvar k = 1; k <= ORDER; k++) begin : g_integ
        cic_integrator #(
            .W(W)
        ) u_integ (
            .clk   (clk),
            .rst   (rst),
            .en_i  (bus.clk_en),
            .x_i   (integ[k-1]),
            .acc_o (integ[k])
        );
    end

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (bus.clk_en) begin
            if (cnt_q == CW'(DECIM - 1)) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Comb chain runs at the decimated rate; differences wrap exactly like the integrators.
    always_comb begin
        comb_c[0] = integ[ORDER];
        for (int k = 1; k <= ORDER; k++) begin
            comb_c[k] = comb_c[k-1] - dly_q[k-1];
        end
        comb_shifted = comb_c[ORDER] >>> SHIFT;
        pcm_d        = OUT_WIDTH'(sat_signed(64'(comb_shifted), OUT_WIDTH));
    end

    // NOTE: the comb delay bank is small and must start from zero, so it is reset like any register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            pcm_q   <= '0;
            valid_q <= 1'b0;
            for (int k = 0; k < ORDER; k++) begin
                dly_q[k] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            valid_q <= tick_q;
            if (tick_q) begin
                pcm_q <= pcm_d;
                for (int k = 0; k < ORDER; k++) begin
                    dly_q[k] <= comb_c[k];
                end
            end
        end
    end

    assign bus.pcm_out   = pcm_q;
    assign bus.pcm_valid = valid_q;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Directed bench for dsm_cic_decimator at ORDER=3, DECIM=32, OUT_WIDTH=16.
module tb_dsm_cic_decimator;

    localparam int DECIM = 32;

    logic clk = 1'b0;
    logic rst;

    dsm_cic_if #(.OUT_WIDTH(16)) bus ();

    dsm_cic_decimator #(
        .ORDER     (3),
        .DECIM     (DECIM),
        .OUT_WIDTH (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] samp[$];
    int                 samp_edge[$];
    int                 hold_err;
    int                 timed_out;

    // mode 0: all ones, 1: all zeros, 2: 1,0,..., 3: 1,1,1,0,...
    function automatic logic pattern_bit(input int mode, input int idx);
        case (mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (idx % 2) == 0;
            default: return (idx % 4) != 3;
        endcase
    endfunction

    task automatic apply_reset();
        rst        = 1'b0;
        bus.clk_en = 1'b0;
        bus.dsm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Drives the pattern on qualified edges (random junk elsewhere) and records each
    // pcm_valid sample with the edge number it appeared on (edge 1 = first driven edge).
    task automatic run_stream(input int mode, input int div, input int n_samples);
        int                 qi;
        logic signed [15:0] last;
        qi = 0;
        samp.delete();
        samp_edge.delete();
        hold_err  = 0;
        timed_out = 0;
        last      = bus.pcm_out;
        for (int k = 1; k <= n_samples * DECIM * div + 64; k++) begin
            bus.clk_en = (div == 1) || ((k % div) == 1);
            if (bus.clk_en) begin
                bus.dsm_in = pattern_bit(mode, qi);
                qi++;
            end else begin
                bus.dsm_in = 1'($urandom);
            end
            @(posedge clk);
            #1;
            if (bus.pcm_valid) begin
                samp.push_back(bus.pcm_out);
                samp_edge.push_back(k);
            end else if (bus.pcm_out !== last) begin
                hold_err++;
            end
            last = bus.pcm_out;
            if (samp.size() == n_samples) break;
        end
        if (samp.size() < n_samples) timed_out = 1;
        bus.clk_en = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.pcm_out !== 16'sd0) begin
            errors++;
            $display("FAIL reset_pcm_out: got %0d expected 0", bus.pcm_out);
        end
        checks++;
        if (bus.pcm_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_pcm_valid: got %b expected 0", bus.pcm_valid);
        end

        run_stream(0, 1, 3);
        checks++;
        if (timed_out != 0) begin
            errors++;
            $display("FAIL reset_prefill_timeout: got %0d samples expected 3", samp.size());
            return;
        end
        checks++;
        if (int'(bus.pcm_out) !== 32767) begin
            errors++;
            $display("FAIL reset_prefill_value: got %0d expected 32767", bus.pcm_out);
        end

        // 97 qualified edges so far leave cnt=1; 16 more put the frame at cnt=17.
        bus.clk_en = 1'b1;
        bus.dsm_in = 1'b1;
        repeat (16) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.pcm_out !== 16'sd0) begin
            errors++;
            $display("FAIL reset_async_pcm_out: got %0d expected 0", bus.pcm_out);
        end
        checks++;
        if (bus.pcm_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_pcm_valid: got %b expected 0", bus.pcm_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Edge 32 completes the frame and raises dec_tick; edge 33 runs the comb.
        // I3 after n ones is C(n,3): 4960, then 41664 -> combs give 26784.
        run_stream(0, 1, 2);
        checks++;
        if (timed_out != 0) begin
            errors++;
            $display("FAIL reset_restart_timeout: got %0d samples expected 2", samp.size());
            return;
        end
        checks++;
        if (samp_edge[0] !== 33) begin
            errors++;
            $display("FAIL reset_first_latency: got edge %0d expected 33", samp_edge[0]);
        end
        checks++;
        if (int'(samp[0]) !== 4960) begin
            errors++;
            $display("FAIL reset_first_value: got %0d expected 4960", samp[0]);
        end
        checks++;
        if (samp_edge[1] !== 65) begin
            errors++;
            $display("FAIL reset_second_latency: got edge %0d expected 65", samp_edge[1]);
        end
        checks++;
        if (int'(samp[1]) !== 26784) begin
            errors++;
            $display("FAIL reset_second_value: got %0d expected 26784", samp[1]);
        end
    endtask

    task automatic test_const_one();
        apply_reset();
        run_stream(0, 1, 8);
        checks++;
        if (timed_out != 0) begin
            errors++;
            $display("FAIL const_one_timeout: got %0d samples expected 8", samp.size());
            return;
        end
        for (int i = 4; i < 8; i++) begin
            checks++;
            if (int'(samp[i]) !== 32767) begin
                errors++;
                $display("FAIL const_one_value[%0d]: got %0d expected 32767", i, samp[i]);
            end
        end
        for (int i = 1; i < 8; i++) begin
            checks++;
            if (samp_edge[i] - samp_edge[i-1] !== 32) begin
                errors++;
                $display("FAIL const_one_period[%0d]: got %0d expected 32", i,
                         samp_edge[i] - samp_edge[i-1]);
            end
        end
        checks++;
        if (hold_err !== 0) begin
            errors++;
            $display("FAIL const_one_hold: got %0d changes between pulses expected 0", hold_err);
        end
    endtask

    task automatic test_const_zero();
        apply_reset();
        run_stream(1, 1, 8);
        checks++;
        if (timed_out != 0) begin
            errors++;
            $display("FAIL const_zero_timeout: got %0d samples expected 8", samp.size());
            return;
        end
        for (int i = 4; i < 8; i++) begin
            checks++;
            if (int'(samp[i]) !== -32768) begin
                errors++;
                $display("FAIL const_zero_value[%0d]: got %0d expected -32768", i, samp[i]);
            end
        end
    endtask

    task automatic test_alternating();
        apply_reset();
        run_stream(2, 1, 8);
        checks++;
        if (timed_out != 0) begin
            errors++;
            $display("FAIL alternating_timeout: got %0d samples expected 8", samp.size());
            return;
        end
        for (int i = 4; i < 8; i++) begin
            checks++;
            if (int'(samp[i]) !== 0) begin
                errors++;
                $display("FAIL alternating_value[%0d]: got %0d expected 0", i, samp[i]);
            end
        end
    endtask

    task automatic test_three_ones();
        apply_reset();
        run_stream(3, 1, 8);
        checks++;
        if (timed_out != 0) begin
            errors++;
            $display("FAIL three_ones_timeout: got %0d samples expected 8", samp.size());
            return;
        end
        for (int i = 4; i < 8; i++) begin
            checks++;
            if (int'(samp[i]) !== 16384) begin
                errors++;
                $display("FAIL three_ones_value[%0d]: got %0d expected 16384", i, samp[i]);
            end
        end
    endtask

    task automatic test_clk_en_div2();
        apply_reset();
        run_stream(3, 2, 8);
        checks++;
        if (timed_out != 0) begin
            errors++;
            $display("FAIL div2_timeout: got %0d samples expected 8", samp.size());
            return;
        end
        for (int i = 4; i < 8; i++) begin
            checks++;
            if (int'(samp[i]) !== 16384) begin
                errors++;
                $display("FAIL div2_value[%0d]: got %0d expected 16384", i, samp[i]);
            end
        end
        for (int i = 1; i < 8; i++) begin
            checks++;
            if (samp_edge[i] - samp_edge[i-1] !== 64) begin
                errors++;
                $display("FAIL div2_period[%0d]: got %0d expected 64", i,
                         samp_edge[i] - samp_edge[i-1]);
            end
        end
        checks++;
        if (hold_err !== 0) begin
            errors++;
            $display("FAIL div2_hold: got %0d changes between pulses expected 0", hold_err);
        end
    endtask

    initial begin
        rst        = 1'b0;
        bus.clk_en = 1'b0;
        bus.dsm_in = 1'b0;
        test_reset();
        test_const_one();
        test_const_zero();
        test_alternating();
        test_three_ones();
        test_clk_en_div2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
